// File: rtl/tetris_pkg.sv
// Shared board geometry, RGB333 colours and the redraw engine state encoding.
package tetris_pkg;
    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int CELL_W = 64;
    localparam int CELL_H = 24;

    localparam logic [3:0] X_LAST = 4'(COLS - 1);
    localparam logic [4:0] Y_LAST = 5'(ROWS - 1);
    localparam logic [7:0] COLS8  = 8'(COLS);

    localparam logic [8:0] FILL_COLOR = 9'b111_000_111;
    localparam logic [8:0] BG_COLOR   = 9'b000_000_000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CMP,
        S_KICK,
        S_WAITD,
        S_NEXT,
        S_FIN
    } redraw_state_t;
endpackage

// File: rtl/board_redraw_shadow_bitmap.sv
// Last-painted value per board cell; combinational read and single-bit write at (x,y).
// Cleared on reset so it matches a screen blanked to the background colour.
module shadow_bitmap
    import tetris_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] x,
    input  logic [4:0] y,
    output logic       rd_bit,
    input  logic       wr_en,
    input  logic       wr_bit
);
    logic [COLS*ROWS-1:0] bits;
    logic [7:0]           idx;

    assign idx    = {3'b000, y} * COLS8 + {4'b0000, x};
    assign rd_bit = bits[idx];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bits <= '0;
        end else if (wr_en) begin
            bits[idx] <= wr_bit;
        end
    end
endmodule

// File: rtl/board_redraw.sv
// Scans the board RAM cell by cell and kicks the box painter for forced or changed cells.
// 4 cycles per skipped cell; a painted cell stalls in KICK while paint_busy and in WAITD until paint_done.
module board_redraw
    import tetris_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       req,
    input  logic       force_all,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] rd_x,
    output logic [4:0] rd_y,
    input  logic       rd_data,
    output logic       paint_start,
    output logic [9:0] paint_x0,
    output logic [8:0] paint_y0,
    output logic [8:0] paint_color,
    input  logic       paint_busy,
    input  logic       paint_done
);
    redraw_state_t state;
    logic [3:0]    x;
    logic [4:0]    y;
    logic          force_r;
    logic          v_r;
    logic          shadow_bit;
    logic          shadow_wr;

    // The shadow is updated on the same edge the kick is issued, so an aborted
    // pass never records a cell the painter was not asked to draw.
    assign shadow_wr = (state == S_KICK) && !paint_busy;

    shadow_bitmap u_shadow (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .x        (x),
        .y        (y),
        .rd_bit   (shadow_bit),
        .wr_en    (shadow_wr),
        .wr_bit   (v_r)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            force_r     <= 1'b0;
            v_r         <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_x        <= '0;
            rd_y        <= '0;
            paint_start <= 1'b0;
            paint_x0    <= '0;
            paint_y0    <= '0;
            paint_color <= '0;
        end else begin
            done_o      <= 1'b0;
            paint_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        force_r <= force_all;
                        x       <= '0;
                        y       <= '0;
                        busy_o  <= 1'b1;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    rd_x  <= x;
                    rd_y  <= y;
                    state <= S_WAIT;
                end
                S_WAIT: state <= S_CMP;
                S_CMP: begin
                    v_r <= rd_data;
                    if (force_r || (rd_data != shadow_bit)) begin
                        paint_x0    <= {x, 6'b000000};
                        paint_y0    <= {y, 4'b0000} + {1'b0, y, 3'b000};
                        paint_color <= rd_data ? FILL_COLOR : BG_COLOR;
                        state       <= S_KICK;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_KICK: begin
                    if (!paint_busy) begin
                        paint_start <= 1'b1;
                        state       <= S_WAITD;
                    end
                end
                S_WAITD: begin
                    if (paint_done) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                            done_o <= 1'b1;
                            state  <= S_FIN;
                        end else begin
                            y     <= y + 5'd1;
                            state <= S_ADDR;
                        end
                    end else begin
                        x     <= x + 4'd1;
                        state <= S_ADDR;
                    end
                end
                S_FIN: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_redraw.sv
// Directed bench for board_redraw with a synchronous board RAM and a fixed-latency painter model.
module tb_board_redraw;
    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    logic       force_all = 1'b0;
    logic       busy_o, done_o;
    logic [3:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_data = 1'b0;
    logic       paint_start;
    logic [9:0] paint_x0;
    logic [8:0] paint_y0, paint_color;
    logic       paint_busy;
    logic       paint_done = 1'b0;

    logic       ram [0:199];
    logic       ext_busy = 1'b0;
    logic       outstanding = 1'b0;
    int         lat = 0;
    int         cyc = 0;
    int         n_cmp = 0, n_bad = 0;
    int         starts = 0, doubles = 0, nonbg = 0, dones = 0;
    logic [9:0] last_x = '0;
    logic [8:0] last_y = '0, last_c = '0;
    int         t0, td, s0;

    board_redraw dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .req         (req),
        .force_all   (force_all),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_data     (rd_data),
        .paint_start (paint_start),
        .paint_x0    (paint_x0),
        .paint_y0    (paint_y0),
        .paint_color (paint_color),
        .paint_busy  (paint_busy),
        .paint_done  (paint_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign paint_busy = ext_busy | outstanding;

    // RAM with one-cycle read latency plus a painter that answers two edges after a kick.
    always @(posedge CLOCK_50) begin
        cyc++;
        rd_data    <= ram[int'(rd_y) * 10 + int'(rd_x)];
        paint_done <= 1'b0;
        if (done_o) dones++;
        if (paint_start) begin
            if (outstanding) doubles++;
            starts++;
            last_x = paint_x0;
            last_y = paint_y0;
            last_c = paint_color;
            if (paint_color != 9'h000) nonbg++;
            outstanding <= 1'b1;
            lat         <= 1;
        end else if (outstanding) begin
            if (lat == 0) begin
                paint_done  <= 1'b1;
                outstanding <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic clr();
        starts  = 0;
        doubles = 0;
        nonbg   = 0;
        dones   = 0;
    endtask

    // t_s is the index of the edge that samples req (cyc counts rising edges).
    task automatic kick_pass(input logic f, output int t_s);
        @(negedge CLOCK_50);
        req       = 1'b1;
        force_all = f;
        @(negedge CLOCK_50);
        req       = 1'b0;
        force_all = 1'b0;
        t_s       = cyc;
    endtask

    // Returns the index of the cycle (numbered by its closing edge) in which done_o is high.
    task automatic wait_done(input string tag, input int budget, output int t_d);
        t_d = -1;
        for (int k = 0; k < budget; k++) begin
            if (done_o) begin
                t_d = cyc + 1;
                break;
            end
            @(negedge CLOCK_50);
        end
        if (t_d < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: done_o not seen within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 200; i++) ram[i] = 1'b0;

        tick(3);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_start", 32'(paint_start), 0);
        chk("rst_rdx", 32'(rd_x), 0);
        chk("rst_rdy", 32'(rd_y), 0);
        chk("rst_x0", 32'(paint_x0), 0);
        chk("rst_col", 32'(paint_color), 0);
        resetn = 1'b1;
        tick(2);

        // Forced pass over an empty board paints every cell in background.
        clr();
        kick_pass(1'b1, t0);
        wait_done("t1_done", 6000, td);
        tick(3);
        chk("t1_starts", 32'(starts), 200);
        chk("t1_nonbg", 32'(nonbg), 0);
        chk("t1_lastx", 32'(last_x), 576);
        chk("t1_lasty", 32'(last_y), 456);
        chk("t1_dones", 32'(dones), 1);
        chk("t1_double", 32'(doubles), 0);

        // One occupied cell at (3,5): only that cell is repainted.
        ram[5 * 10 + 3] = 1'b1;
        clr();
        kick_pass(1'b0, t0);
        wait_done("t2_done", 2000, td);
        tick(3);
        chk("t2_starts", 32'(starts), 1);
        chk("t2_x0", 32'(last_x), 192);
        chk("t2_y0", 32'(last_y), 120);
        chk("t2_col", 32'(last_c), 32'h1C7);
        chk("t2_dones", 32'(dones), 1);

        // No change: nothing painted, 200 cells x 4 cycles, done in cycle t0+801.
        clr();
        kick_pass(1'b0, t0);
        wait_done("t3_done", 2000, td);
        chk("t3_lat", 32'(td - t0), 801);
        tick(3);
        chk("t3_starts", 32'(starts), 0);

        // Clearing (3,5) repaints it in background.
        ram[5 * 10 + 3] = 1'b0;
        clr();
        kick_pass(1'b0, t0);
        wait_done("t4_done", 2000, td);
        tick(3);
        chk("t4_starts", 32'(starts), 1);
        chk("t4_x0", 32'(last_x), 192);
        chk("t4_y0", 32'(last_y), 120);
        chk("t4_col", 32'(last_c), 0);

        // Painter busy when the engine reaches KICK: the kick waits until busy drops.
        ram[0] = 1'b1;
        clr();
        @(negedge CLOCK_50);
        ext_busy = 1'b1;
        kick_pass(1'b0, t0);
        tick(15);
        chk("t5_stall", 32'(starts), 0);
        chk("t5_busy", 32'(busy_o), 1);
        ext_busy = 1'b0;
        wait_done("t5_done", 2000, td);
        tick(3);
        chk("t5_starts", 32'(starts), 1);
        chk("t5_x0", 32'(last_x), 0);
        chk("t5_col", 32'(last_c), 32'h1C7);
        chk("t5_double", 32'(doubles), 0);

        // A second req during a pass is dropped, not queued.
        clr();
        kick_pass(1'b1, t0);
        tick(50);
        req       = 1'b1;
        force_all = 1'b1;
        @(negedge CLOCK_50);
        req       = 1'b0;
        force_all = 1'b0;
        wait_done("t6_done", 6000, td);
        tick(100);
        chk("t6_dones", 32'(dones), 1);
        chk("t6_starts", 32'(starts), 200);

        // Reset mid-pass aborts at once; the cleared shadow makes the next pass paint occupied cells.
        ram[12 * 10 + 7] = 1'b1;
        clr();
        kick_pass(1'b1, t0);
        tick(300);
        resetn = 1'b0;
        #1;
        chk("t7_busy", 32'(busy_o), 0);
        chk("t7_start", 32'(paint_start), 0);
        s0 = starts;
        tick(2);
        resetn = 1'b1;
        tick(10);
        chk("t7_nostart", 32'(starts), 32'(s0));
        clr();
        kick_pass(1'b0, t0);
        wait_done("t7_done", 3000, td);
        tick(3);
        chk("t7_starts", 32'(starts), 2);
        chk("t7_nonbg", 32'(nonbg), 2);
        chk("t7_lastx", 32'(last_x), 448);
        chk("t7_lasty", 32'(last_y), 288);
        chk("t7_dones", 32'(dones), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
